// File: rtl/uart_tx_serializer.sv
// UART transmitter: pops bytes from an upstream FIFO and sends them LSB first, OVERSAMPLE BAUD_EN ticks per bit.
// Optional parity bit is built only when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
   parameter int RD_LAT     = 2,
   parameter int OVERSAMPLE = 16
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       BAUD_EN,
   input  logic       BIT8,
   input  logic       PARITY_EN,
   input  logic       ODD_N_EVEN,
   input  logic       FIFO_EMPTY,
   input  logic [7:0] FIFO_DATA,
   output logic       FIFO_RDB,
   output logic       TX,
   output logic       TX_BUSY
);
   localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [1:0]    WAIT_LAST = 2'(RD_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [1:0]    wait_q, wait_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          bit8_q, bit8_d;
   logic          armed_q;
   logic          tx_q, tx_d;
   logic          rdb_q, rdb_d;
   logic          busy_q, busy_d;
   logic          tick_done;
   logic [2:0]    bit_last;

`ifdef UART_TX_PARITY_EN
   logic          par_en_q, par_en_d;
   logic          par_q, par_d;
`else
   logic          unused_parity_cfg;
   assign unused_parity_cfg = PARITY_EN ^ ODD_N_EVEN;
`endif

   assign tick_done = BAUD_EN && (tick_q == TICK_LAST);
   assign bit_last  = bit8_q ? 3'd7 : 3'd6;

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      wait_d  = wait_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      bit8_d  = bit8_q;
      tx_d    = tx_q;
      rdb_d   = 1'b1;
      busy_d  = busy_q;
`ifdef UART_TX_PARITY_EN
      par_en_d = par_en_q;
      par_d    = par_q;
`endif
      // Ticks only count inside the serial bit states; FETCH/WAIT ignore BAUD_EN.
      if ((state_q inside {S_START, S_DATA, S_PARITY, S_STOP}) && BAUD_EN)
         tick_d = tick_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (armed_q && !FIFO_EMPTY) begin
               state_d = S_FETCH;
               rdb_d   = 1'b0;
               busy_d  = 1'b1;
            end
         end
         S_FETCH: begin
            state_d = S_WAIT;
            wait_d  = 2'd0;
         end
         S_WAIT: begin
            if (wait_q == WAIT_LAST) begin
               sh_d    = FIFO_DATA;
               bit8_d  = BIT8;
`ifdef UART_TX_PARITY_EN
               par_en_d = PARITY_EN;
               par_d    = ^(FIFO_DATA & {BIT8, 7'h7F}) ^ ODD_N_EVEN;
`endif
               state_d = S_START;
               tick_d  = '0;
               tx_d    = 1'b0;
            end else begin
               wait_d = wait_q + 2'd1;
            end
         end
         S_START: begin
            if (tick_done) begin
               state_d = S_DATA;
               tick_d  = '0;
               bit_d   = 3'd0;
               tx_d    = sh_q[0];
            end
         end
         S_DATA: begin
            if (tick_done) begin
               tick_d = '0;
               if (bit_q == bit_last) begin
`ifdef UART_TX_PARITY_EN
                  if (par_en_q) begin
                     state_d = S_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
`else
                  state_d = S_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
                  sh_d  = {1'b0, sh_q[7:1]};
                  tx_d  = sh_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (tick_done) begin
               state_d = S_STOP;
               tick_d  = '0;
               tx_d    = 1'b1;
            end
         end
`endif
         S_STOP: begin
            tx_d = 1'b1;
            if (tick_done) begin
               tick_d = '0;
               if (!FIFO_EMPTY) begin
                  state_d = S_FETCH;
                  rdb_d   = 1'b0;
               end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // armed_q holds off the first fetch until the second edge after reset release.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= S_IDLE;
         tick_q   <= '0;
         wait_q   <= '0;
         bit_q    <= '0;
         sh_q     <= '0;
         bit8_q   <= 1'b0;
         armed_q  <= 1'b0;
         tx_q     <= 1'b1;
         rdb_q    <= 1'b1;
         busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         wait_q   <= wait_d;
         bit_q    <= bit_d;
         sh_q     <= sh_d;
         bit8_q   <= bit8_d;
         armed_q  <= 1'b1;
         tx_q     <= tx_d;
         rdb_q    <= rdb_d;
         busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
         par_en_q <= par_en_d;
         par_q    <= par_d;
`endif
      end
   end

   assign TX       = tx_q;
   assign FIFO_RDB = rdb_q;
   assign TX_BUSY  = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: FIFO model with read latency, line monitor decoding frames against byte/config rules.
module tb_uart_tx_serializer;
   localparam int RD_LAT     = 2;
   localparam int OVERSAMPLE = 16;

   logic       CLK        = 1'b0;
   logic       RESET_N    = 1'b0;
   logic       BAUD_EN    = 1'b0;
   logic       BIT8       = 1'b1;
   logic       PARITY_EN  = 1'b0;
   logic       ODD_N_EVEN = 1'b0;
   logic       FIFO_EMPTY = 1'b1;
   logic [7:0] FIFO_DATA  = 8'h00;
   logic       FIFO_RDB;
   logic       TX;
   logic       TX_BUSY;

   int n_checks = 0;
   int n_fail   = 0;
   int baud_den = 1;
   int exp_frames = 0;

   logic [7:0] fifo_q[$];
   logic [7:0] popped_q[$];
   logic       pop_seen;
   logic [7:0] lat_val = 8'h00;
   int         lat_cnt = 0;

   logic       mon_in_frame = 1'b0;
   int         mon_idx = 0, mon_ticks = 0, mon_len = 0, mon_gap = 0;
   logic       mon_b2b = 1'b0;
   logic       prev_rdb_low = 1'b0;
   logic       exp_bits [12];
   logic [7:0] mon_byte;
   int         mon_nd;
   int         frames_done = 0;
   int         rdb_pulses = 0;
   int         cyc = 0;

   uart_tx_serializer #(.RD_LAT(RD_LAT), .OVERSAMPLE(OVERSAMPLE)) dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .BAUD_EN    (BAUD_EN),
      .BIT8       (BIT8),
      .PARITY_EN  (PARITY_EN),
      .ODD_N_EVEN (ODD_N_EVEN),
      .FIFO_EMPTY (FIFO_EMPTY),
      .FIFO_DATA  (FIFO_DATA),
      .FIFO_RDB   (FIFO_RDB),
      .TX         (TX),
      .TX_BUSY    (TX_BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(posedge CLK) begin
      cyc++;
      if (cyc > 90000) begin
         $display("FAIL watchdog: observed cycle %0d, expected end before 90000", cyc);
         $fatal(1, "watchdog");
      end
   end

   always @(posedge CLK) begin
      #1;
      BAUD_EN = (baud_den <= 1) ? 1'b1 : ($urandom_range(baud_den - 1, 0) == 0);
   end

   // Upstream FIFO: data shows the popped byte from RD_LAT cycles after the strobe cycle, stale before that.
   always @(posedge CLK) begin
      pop_seen = (RESET_N === 1'b1) && (FIFO_RDB === 1'b0);
      #1;
      if (pop_seen && fifo_q.size() > 0) begin
         lat_val = fifo_q.pop_front();
         popped_q.push_back(lat_val);
         FIFO_DATA = ~lat_val;
         lat_cnt = RD_LAT - 1;
         if (lat_cnt == 0) FIFO_DATA = lat_val;
      end else if (lat_cnt > 0) begin
         lat_cnt--;
         if (lat_cnt == 0) FIFO_DATA = lat_val;
      end
      FIFO_EMPTY = (fifo_q.size() == 0);
   end

   // Line monitor: expected frame = start, data LSB first, optional parity, stop; each bit OVERSAMPLE ticks.
   always @(negedge CLK) begin
      if (RESET_N !== 1'b1) begin
         mon_in_frame = 1'b0;
         mon_b2b = 1'b0;
         mon_gap = 0;
         prev_rdb_low = 1'b0;
      end else begin
         if (FIFO_RDB === 1'b0) begin
            rdb_pulses++;
            check("rdb_while_empty", FIFO_EMPTY, 1'b0);
            check("rdb_width", prev_rdb_low, 1'b0);
         end
         prev_rdb_low = (FIFO_RDB === 1'b0);
         if (!mon_in_frame) begin
            if (TX === 1'b0) begin
               check("frame_has_popped_byte", popped_q.size() > 0, 1);
               mon_byte = (popped_q.size() > 0) ? popped_q.pop_front() : 8'h00;
               mon_nd = BIT8 ? 8 : 7;
               exp_bits[0] = 1'b0;
               for (int i = 0; i < mon_nd; i++) exp_bits[1 + i] = mon_byte[i];
               mon_len = 1 + mon_nd;
`ifdef UART_TX_PARITY_EN
               if (PARITY_EN) begin
                  exp_bits[mon_len] = 1'(($countones(mon_byte & (BIT8 ? 8'hFF : 8'h7F)) % 2)) ^ ODD_N_EVEN;
                  mon_len++;
               end
`endif
               exp_bits[mon_len] = 1'b1;
               mon_len++;
               if (mon_b2b) check("b2b_gap_short", mon_gap <= RD_LAT + 1, 1);
               mon_in_frame = 1'b1;
               mon_idx = 0;
               mon_ticks = 0;
            end else begin
               mon_gap++;
            end
         end
         if (mon_in_frame) begin
            check($sformatf("tx_bit%0d", mon_idx), TX, exp_bits[mon_idx]);
            check("busy_in_frame", TX_BUSY, 1'b1);
            if (BAUD_EN) mon_ticks++;
            if (mon_ticks == OVERSAMPLE) begin
               mon_ticks = 0;
               mon_idx++;
               if (mon_idx == mon_len) begin
                  mon_in_frame = 1'b0;
                  frames_done++;
                  mon_b2b = !FIFO_EMPTY;
                  mon_gap = 0;
               end
            end
         end
      end
   end

   task automatic push(input logic [7:0] v);
      @(negedge CLK);
      fifo_q.push_back(v);
   endtask

   task automatic wait_frames(input int target, input int budget);
      int n = 0;
      while (frames_done < target && n < budget) begin
         @(negedge CLK);
         n++;
      end
      check("frames_complete", frames_done >= target, 1);
   endtask

   task automatic send_and_time(input logic [7:0] v, input int exp_cycles, input string tag);
      int n;
      push(v);
      exp_frames++;
      n = 0;
      while (TX !== 1'b0 && n < 100) begin
         @(negedge CLK);
         n++;
      end
      check({tag, "_start"}, TX, 1'b0);
      n = 0;
      while (TX_BUSY !== 1'b0 && n < 400) begin
         @(negedge CLK);
         n++;
      end
      check({tag, "_len"}, n, exp_cycles);
   endtask

   initial begin
      int p0;
      int nb;
      int par_bits;
`ifdef UART_TX_PARITY_EN
      par_bits = 1;
`else
      par_bits = 0;
`endif
      RESET_N = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("reset_tx", TX, 1'b1);
      check("reset_rdb", FIFO_RDB, 1'b1);
      check("reset_busy", TX_BUSY, 1'b0);
      @(posedge CLK);
      #1 RESET_N = 1'b1;

      for (int i = 0; i < 1000; i++) begin
         @(negedge CLK);
         check("empty_idle", {FIFO_RDB, TX, TX_BUSY}, 3'b110);
      end

      baud_den = 1;
      BIT8 = 1'b1; PARITY_EN = 1'b0; ODD_N_EVEN = 1'b0;
      p0 = rdb_pulses;
      send_and_time(8'h55, 160, "f55");
      check("f55_rdb_pulses", rdb_pulses - p0, 1);
      check("f55_frames", frames_done, exp_frames);

      BIT8 = 1'b0; PARITY_EN = 1'b1; ODD_N_EVEN = 1'b1;
      send_and_time(8'h80, (9 + par_bits) * OVERSAMPLE, "f80_7bit_odd");
      BIT8 = 1'b1; PARITY_EN = 1'b1; ODD_N_EVEN = 1'b0;
      send_and_time(8'hA5, (10 + par_bits) * OVERSAMPLE, "fa5_par");
      check("dir_frames", frames_done, exp_frames);

      BIT8 = 1'b1; PARITY_EN = 1'b0;
      p0 = rdb_pulses;
      @(negedge CLK);
      fifo_q.push_back(8'h0F);
      fifo_q.push_back(8'hF0);
      exp_frames += 2;
      wait_frames(exp_frames, 1000);
      repeat (5) @(negedge CLK);
      check("b2b_rdb_pulses", rdb_pulses - p0, 2);
      check("b2b_idle_busy", TX_BUSY, 1'b0);

      for (int s = 0; s < 6; s++) begin
         BIT8 = 1'($urandom_range(1, 0));
         PARITY_EN = 1'($urandom_range(1, 0));
         ODD_N_EVEN = 1'($urandom_range(1, 0));
         baud_den = $urandom_range(4, 1);
         nb = $urandom_range(4, 1);
         for (int k = 0; k < nb; k++) begin
            push(8'($urandom));
            exp_frames++;
            if ($urandom_range(1, 0) == 1) repeat ($urandom_range(300, 1)) @(negedge CLK);
         end
         wait_frames(exp_frames, 9000);
         repeat (5) @(negedge CLK);
         check("rand_idle_busy", TX_BUSY, 1'b0);
      end

      baud_den = 1;
      BIT8 = 1'b1; PARITY_EN = 1'b0;
      push(8'hC3);
      begin
         int n = 0;
         while (!(mon_in_frame && mon_idx == 4) && n < 200) begin
            @(negedge CLK);
            n++;
         end
         check("reached_data_bit3", mon_idx, 4);
      end
      repeat (3) @(posedge CLK);
      #1 RESET_N = 1'b0;
      #1;
      check("midframe_reset_tx", TX, 1'b1);
      check("midframe_reset_rdb", FIFO_RDB, 1'b1);
      check("midframe_reset_busy", TX_BUSY, 1'b0);
      popped_q.delete();
      repeat (3) @(posedge CLK);
      #1 RESET_N = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         check("no_fetch_after_reset", {FIFO_RDB, TX}, 2'b11);
      end

      @(posedge CLK);
      #1 RESET_N = 1'b0;
      push(8'h3C);
      exp_frames = frames_done + 1;
      repeat (2) @(posedge CLK);
      #1 RESET_N = 1'b1;
      @(posedge CLK);
      #1;
      check("no_fetch_first_edge", FIFO_RDB, 1'b1);
      wait_frames(exp_frames, 600);
      repeat (5) @(negedge CLK);
      check("final_busy", TX_BUSY, 1'b0);
      check("leftover_popped", popped_q.size(), 0);
      check("leftover_fifo", fifo_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
